intr_ctrl: RTL
==============

Name: intr_ctrl

Overview:
MMIO interrupt controller that sequences the OTTER CPU_INTR line for several event sources. Sources are a built-in periodic tick timer (source 0, used for the game tick) and external pre-debounced one-shot inputs such as the button. It sits on the IOBUS beside the switch, LED, seven-segment and random-number peripherals. It latches events into pending bits, gates them with a mask, and asserts a fixed-length INTR pulse. After the pulse it holds off further interrupts until software writes ACK.

Parameters:
BASE_AD, 32'h11000080, base address of the register block
NUM_SRC, 4, number of sources including timer bit 0; legal range 2..32
PULSE_LEN, 2, INTR high time in CLK cycles; legal range 1..255

Ports:
CLK  in  1  system clock; the CPU clock domain
RST_N  in  1  asynchronous active-low reset
IOBUS_ADDR  in  32  CPU IOBUS address
IOBUS_OUT  in  32  CPU write data
IOBUS_WR  in  1  CPU write strobe, one cycle per store
SRC  in  NUM_SRC-1  external event inputs mapped to pending bits 1..NUM_SRC-1; synchronous to CLK and already debounced
RD_DATA  out  32  combinational read data; the wrapper ORs it into IOBUS_in
RD_HIT  out  1  high when IOBUS_ADDR decodes to a readable register
INTR  out  1  interrupt request to CPU_INTR

Behaviour:
Register map (offsets from BASE_AD):
- +0x0 PEND: R, W1C
- +0x4 MASK: R/W
- +0x8 ACK: W, data ignored
- +0xC TPER: R/W timer period
- +0x10 TCNT: R only
- Writes to any other address are ignored.
- Registers narrower than 32 bits read back zero-extended.

Reset (RST_N low, asynchronous):
- PEND=0, MASK=0, TPER=0, TCNT=0, src_q=0, state=IDLE, pulse count=0, INTR=0.
- Reset asserted mid-pulse drops INTR immediately.

Edge detect:
- src_q registers SRC each cycle.
- Event i (i≥1) fires when SRC[i]=1 and src_q[i]=0, so it is a rising edge.
- PEND[i] is set on the following CLK edge.
- A level held high produces exactly one event.

Timer (source 0):
- TPER=0 disables the timer and holds TCNT at 0.
- Otherwise TCNT increments each cycle.
- When TCNT==TPER-1, TCNT wraps to 0 on the next edge and PEND[0] is set on that same edge.
- TPER=1 therefore sets PEND[0] every cycle.
- A write to TPER loads TPER and clears TCNT to 0 on the same edge. No event is generated on that edge.
- 32-bit unsigned; no overflow is possible.

PEND update each cycle:
- PEND_next = (PEND & ~clr) | set.
- clr = IOBUS_OUT[NUM_SRC-1:0] on a PEND write, else 0.
- set wins over clear for the same bit in the same cycle.

FSM:
- IDLE: INTR=0. If |(PEND & MASK), go to ASSERT and load the pulse counter with PULSE_LEN-1.
- ASSERT: INTR=1 (registered output). Decrement the counter; at 0 go to WAIT_ACK.
- WAIT_ACK: INTR=0. Stay here until an ACK write, then go to IDLE.
- ACK write during ASSERT: INTR drops next edge and the FSM goes to IDLE.
- ACK write during IDLE: ignored.
- Latency from event to INTR is 2 cycles: pending set, then IDLE→ASSERT.
- Events arriving in ASSERT or WAIT_ACK still latch into PEND. They cause a new interrupt after ACK if still pending and unmasked.
- MASK changes affect only the IDLE decision. Clearing MASK in ASSERT does not truncate the pulse.

Read path:
- RD_DATA/RD_HIT are pure combinational decode of IOBUS_ADDR.
- Unmapped address gives RD_DATA=0, RD_HIT=0.
- The ACK address reads 0 with RD_HIT=0.

Test Plan:
- Reset then read: pulse RST_N low mid-run → PEND/MASK/TPER/TCNT read 0, INTR=0 asynchronously; RD_HIT=0 at 0x11000000.
- Masked external event: MASK=0x2, SRC[1] rising edge → PEND=0x2 after 1 cycle, INTR high exactly 2 cycles starting 2 cycles after the edge. SRC[2] edge with MASK bit clear → PEND=0x6, no INTR.
- ACK handshake: after the pulse, a second SRC[1] edge → no INTR while in WAIT_ACK. Then ACK + W1C 0x2 → IDLE with PEND still showing bit 2 only, no INTR since bit 2 is masked. Next SRC[1] edge → new pulse.
- Timer: TPER=5, MASK=0x1 → PEND[0] set every 5 cycles, TCNT sequence 0,1,2,3,4,0. TPER=0 → TCNT=0 and no further events. Writing TPER=3 mid-count → TCNT restarts at 0.
- Simultaneous set/clear: W1C 0x1 on the same edge the timer wraps → PEND[0] remains 1.
- ACK during ASSERT with PULSE_LEN=4: ACK in the 2nd pulse cycle → INTR low next edge. With PEND&MASK still nonzero, INTR re-asserts 1 cycle later.

Source files
------------

// File: rtl/intr_ctrl.sv
// MMIO interrupt controller for the OTTER IOBUS: edge-latched sources plus a
// periodic tick timer, masked into a fixed-length INTR pulse with ACK hold-off.
module intr_ctrl #(
    parameter logic [31:0] BASE_AD   = 32'h11000080,
    parameter int          NUM_SRC   = 4,
    parameter int          PULSE_LEN = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [31:0]          IOBUS_ADDR,
    input  logic [31:0]          IOBUS_OUT,
    input  logic                 IOBUS_WR,
    input  logic [NUM_SRC-1:1]   SRC,
    output logic [31:0]          RD_DATA,
    output logic                 RD_HIT,
    output logic                 INTR
);

    localparam logic [31:0] A_PEND = BASE_AD;
    localparam logic [31:0] A_MASK = BASE_AD + 32'h4;
    localparam logic [31:0] A_ACK  = BASE_AD + 32'h8;
    localparam logic [31:0] A_TPER = BASE_AD + 32'hC;
    localparam logic [31:0] A_TCNT = BASE_AD + 32'h10;
    localparam logic [7:0]  PULSE_INIT = 8'(PULSE_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_ACK} state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic                 r_intr;
    logic [NUM_SRC-1:0]   r_pend;
    logic [NUM_SRC-1:0]   r_mask;
    logic [NUM_SRC-1:1]   r_src_q;
    logic [31:0]          r_tper;
    logic [31:0]          r_tcnt;

    logic                 w_wr_pend, w_wr_mask, w_ack, w_wr_tper;
    logic                 w_tick;
    logic [NUM_SRC-1:0]   w_set, w_clr;

    assign w_wr_pend = IOBUS_WR && (IOBUS_ADDR == A_PEND);
    assign w_wr_mask = IOBUS_WR && (IOBUS_ADDR == A_MASK);
    assign w_ack     = IOBUS_WR && (IOBUS_ADDR == A_ACK);
    assign w_wr_tper = IOBUS_WR && (IOBUS_ADDR == A_TPER);

    // A TPER write restarts the count and suppresses the wrap event on that edge.
    assign w_tick = !w_wr_tper && (r_tper != 32'd0) && (r_tcnt == r_tper - 32'd1);
    assign w_set  = {SRC & ~r_src_q, w_tick};
    assign w_clr  = w_wr_pend ? IOBUS_OUT[NUM_SRC-1:0] : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tper <= '0;
            r_tcnt <= '0;
        end else if (w_wr_tper) begin
            r_tper <= IOBUS_OUT;
            r_tcnt <= '0;
        end else if (r_tper == 32'd0 || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_src_q <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
        end else begin
            r_src_q <= SRC;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_wr_mask)
                r_mask <= IOBUS_OUT[NUM_SRC-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_intr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|(r_pend & r_mask)) begin
                        r_state <= S_ASSERT;
                        r_cnt   <= PULSE_INIT;
                        r_intr  <= 1'b1;
                    end
                end
                S_ASSERT: begin
                    if (w_ack) begin
                        r_state <= S_IDLE;
                        r_intr  <= 1'b0;
                    end else if (r_cnt == 8'd0) begin
                        r_state <= S_WAIT_ACK;
                        r_intr  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_ack)
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

    assign INTR = r_intr;

    always_comb begin
        RD_DATA = '0;
        RD_HIT  = 1'b0;
        case (IOBUS_ADDR)
            A_PEND: begin RD_DATA = 32'(r_pend); RD_HIT = 1'b1; end
            A_MASK: begin RD_DATA = 32'(r_mask); RD_HIT = 1'b1; end
            A_TPER: begin RD_DATA = r_tper;      RD_HIT = 1'b1; end
            A_TCNT: begin RD_DATA = r_tcnt;      RD_HIT = 1'b1; end
            default: ;
        endcase
    end

endmodule
